udp_tx_arbiter: RTL and testbench

- Packet-level round-robin arbiter that shares the single 64-bit UDP TX AXI-Stream path between NUM_CH user channels.
- Sits between user/application streams and the UDP TX header-insertion block.
- Latches per-channel UDP metadata (ports, payload length) at grant and holds it stable for the whole packet.
- Never interleaves beats of different packets.

---
 rtl/udp_tx_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_udp_tx_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: packet-level round-robin arbiter that shares one 64-bit
// UDP TX AXI-Stream path between NUM_CH user channels. The UDP metadata
// (ports, length) is latched at grant and held until the next grant.
// Beats of different packets are never interleaved.
// Optional stall watchdog: define UDP_ARB_TIMEOUT_EN. It closes a stalled
// packet with a synthetic error beat, then drains the channel in FLUSH.
module udp_tx_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 64,
  parameter int KEEP_W      = 8,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                     tx_axis_aclk,
  input  logic                     tx_axis_aresetn,
  input  logic [NUM_CH*DATA_W-1:0] ch_tx_axis_tdata,
  input  logic [NUM_CH*KEEP_W-1:0] ch_tx_axis_tkeep,
  input  logic [NUM_CH-1:0]        ch_tx_axis_tvalid,
  input  logic [NUM_CH-1:0]        ch_tx_axis_tlast,
  input  logic [NUM_CH-1:0]        ch_tx_axis_tuser,
  output logic [NUM_CH-1:0]        ch_tx_axis_tready,
  input  logic [NUM_CH*16-1:0]     ch_src_port,
  input  logic [NUM_CH*16-1:0]     ch_dst_port,
  input  logic [NUM_CH*16-1:0]     ch_length,
  output logic [DATA_W-1:0]        udp_tx_axis_tdata,
  output logic [KEEP_W-1:0]        udp_tx_axis_tkeep,
  output logic                     udp_tx_axis_tvalid,
  output logic                     udp_tx_axis_tlast,
  output logic                     udp_tx_axis_tuser,
  input  logic                     udp_tx_axis_tready,
  output logic [15:0]              udp_tx_src_port,
  output logic [15:0]              udp_tx_dst_port,
  output logic [15:0]              udp_tx_length,
  output logic [NUM_CH-1:0]        udp_tx_grant,
  output logic                     udp_tx_busy
);

  localparam int IDX_W = $clog2(NUM_CH);

`ifdef UDP_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_XFER = 2'd1, ST_FLUSH = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_XFER = 2'd1} state_t;
`endif

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  rr_ptr_reg;
  logic [IDX_W-1:0]  grant_idx_reg;
  logic [NUM_CH-1:0] grant_reg;
  logic [15:0]       src_port_reg, dst_port_reg, length_reg;

  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  cand;
  logic              gnt_valid, gnt_user, beat_fire;
  logic              synth_active, flush_active, xfer_ready;

  // Per-channel views of the flattened input buses
  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic [KEEP_W-1:0] ch_keep [NUM_CH];
  logic [15:0]       ch_src  [NUM_CH];
  logic [15:0]       ch_dst  [NUM_CH];
  logic [15:0]       ch_len  [NUM_CH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_split
      assign ch_data[gi] = ch_tx_axis_tdata[gi*DATA_W +: DATA_W];
      assign ch_keep[gi] = ch_tx_axis_tkeep[gi*KEEP_W +: KEEP_W];
      assign ch_src[gi]  = ch_src_port[gi*16 +: 16];
      assign ch_dst[gi]  = ch_dst_port[gi*16 +: 16];
      assign ch_len[gi]  = ch_length[gi*16 +: 16];
      // Only the granted channel ever sees ready
      assign ch_tx_axis_tready[gi] = grant_reg[gi] & (xfer_ready | flush_active);
    end
  endgenerate

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    return (v == IDX_W'(NUM_CH - 1)) ? '0 : v + 1'b1;
  endfunction

  assign gnt_valid  = ch_tx_axis_tvalid[grant_idx_reg];
  assign gnt_user   = ch_tx_axis_tuser[grant_idx_reg];
  assign beat_fire  = udp_tx_axis_tvalid & udp_tx_axis_tready;
  assign xfer_ready = (state_reg == ST_XFER) & ~synth_active & udp_tx_axis_tready;

  assign udp_tx_src_port = src_port_reg;
  assign udp_tx_dst_port = dst_port_reg;
  assign udp_tx_length   = length_reg;
  assign udp_tx_grant    = grant_reg;
  assign udp_tx_busy     = (state_reg != ST_IDLE);

`ifdef UDP_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] stall_cnt_reg;
  logic             synth_reg;
  logic             gnt_last;

  assign gnt_last     = ch_tx_axis_tlast[grant_idx_reg];
  assign synth_active = synth_reg;
  assign flush_active = (state_reg == ST_FLUSH);

  // Stall watchdog: count consecutive bubble cycles, arm the synthetic beat at the limit
  always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn) begin
    if (!tx_axis_aresetn) begin
      stall_cnt_reg <= '0;
      synth_reg     <= 1'b0;
    end else if (state_reg != ST_XFER) begin
      stall_cnt_reg <= '0;
      synth_reg     <= 1'b0;
    end else if (synth_reg) begin
      stall_cnt_reg <= '0;
      if (beat_fire) synth_reg <= 1'b0;
    end else if (gnt_valid) begin
      stall_cnt_reg <= '0;
    end else if (stall_cnt_reg == CNT_W'(TIMEOUT_CYC - 1)) begin
      stall_cnt_reg <= '0;
      synth_reg     <= 1'b1;
    end else begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end
`else
  assign synth_active = 1'b0;
  assign flush_active = 1'b0;
`endif

  // Round-robin search: first requester at or after rr_ptr, with wrap
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = rr_ptr_reg;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!pick_valid && ch_tx_axis_tvalid[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  // State register
  always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn) begin
    if (!tx_axis_aresetn) state_reg <= ST_IDLE;
    else                  state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (pick_valid) state_next = ST_XFER;
      ST_XFER: begin
        if (beat_fire && udp_tx_axis_tlast) begin
`ifdef UDP_ARB_TIMEOUT_EN
          state_next = synth_reg ? ST_FLUSH : ST_IDLE;
`else
          state_next = ST_IDLE;
`endif
        end
      end
`ifdef UDP_ARB_TIMEOUT_EN
      ST_FLUSH: if (gnt_valid && gnt_last) state_next = ST_IDLE;
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // Output mux: granted channel's beat, or the synthetic error beat after a timeout
  always_comb begin
    udp_tx_axis_tdata  = '0;
    udp_tx_axis_tkeep  = '0;
    udp_tx_axis_tvalid = 1'b0;
    udp_tx_axis_tlast  = 1'b0;
    udp_tx_axis_tuser  = 1'b0;
    if (state_reg == ST_XFER) begin
      if (synth_active) begin
        udp_tx_axis_tkeep  = KEEP_W'(1);
        udp_tx_axis_tvalid = 1'b1;
        udp_tx_axis_tlast  = 1'b1;
        udp_tx_axis_tuser  = 1'b1;
      end else begin
        udp_tx_axis_tdata  = ch_data[grant_idx_reg];
        udp_tx_axis_tkeep  = ch_keep[grant_idx_reg];
        udp_tx_axis_tvalid = gnt_valid;
        udp_tx_axis_tlast  = ch_tx_axis_tlast[grant_idx_reg];
        udp_tx_axis_tuser  = gnt_user;
      end
    end
  end

  // Grant, metadata latch and round-robin pointer update
  always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn) begin
    if (!tx_axis_aresetn) begin
      rr_ptr_reg    <= '0;
      grant_idx_reg <= '0;
      grant_reg     <= '0;
      src_port_reg  <= '0;
      dst_port_reg  <= '0;
      length_reg    <= '0;
    end else if (state_reg == ST_IDLE && pick_valid) begin
      grant_idx_reg <= pick_idx;
      grant_reg     <= NUM_CH'(1) << pick_idx;
      src_port_reg  <= ch_src[pick_idx];
      dst_port_reg  <= ch_dst[pick_idx];
      length_reg    <= ch_len[pick_idx];
    end else if (state_reg != ST_IDLE && state_next == ST_IDLE) begin
      grant_reg     <= '0;
      rr_ptr_reg    <= wrap_inc(grant_idx_reg);
    end
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb_udp_tx_arbiter: directed bench for udp_tx_arbiter. A cycle table covers
// round-robin order, backpressure and pointer wrap; hand sequences cover the
// single-channel packet, mid-packet reset and (with UDP_ARB_TIMEOUT_EN) the watchdog.
module tb_udp_tx_arbiter;
  localparam int NCH = 4;
  localparam int NV  = 28;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH*64-1:0] ch_tdata = '0;
  logic [NCH*8-1:0]  ch_tkeep = '0;
  logic [NCH-1:0]    ch_tvalid = '0, ch_tlast = '0, ch_tuser = '0, ch_tready;
  logic [NCH*16-1:0] ch_src = '0, ch_dst = '0, ch_len = '0;
  logic [63:0]       o_tdata;
  logic [7:0]        o_tkeep;
  logic              o_tvalid, o_tlast, o_tuser;
  logic              ds_ready = 1'b1;
  logic [15:0]       o_src, o_dst, o_len;
  logic [NCH-1:0]    grant;
  logic              busy;

  always #5 clk = ~clk;

  udp_tx_arbiter #(.NUM_CH(NCH), .DATA_W(64), .KEEP_W(8), .TIMEOUT_CYC(16)) dut (
    .tx_axis_aclk       (clk),
    .tx_axis_aresetn    (rst_n),
    .ch_tx_axis_tdata   (ch_tdata),
    .ch_tx_axis_tkeep   (ch_tkeep),
    .ch_tx_axis_tvalid  (ch_tvalid),
    .ch_tx_axis_tlast   (ch_tlast),
    .ch_tx_axis_tuser   (ch_tuser),
    .ch_tx_axis_tready  (ch_tready),
    .ch_src_port        (ch_src),
    .ch_dst_port        (ch_dst),
    .ch_length          (ch_len),
    .udp_tx_axis_tdata  (o_tdata),
    .udp_tx_axis_tkeep  (o_tkeep),
    .udp_tx_axis_tvalid (o_tvalid),
    .udp_tx_axis_tlast  (o_tlast),
    .udp_tx_axis_tuser  (o_tuser),
    .udp_tx_axis_tready (ds_ready),
    .udp_tx_src_port    (o_src),
    .udp_tx_dst_port    (o_dst),
    .udp_tx_length      (o_len),
    .udp_tx_grant       (grant),
    .udp_tx_busy        (busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int k, input logic v, input logic l, input logic u,
                       input logic [63:0] d, input logic [7:0] kp);
    ch_tvalid[k]          = v;
    ch_tlast[k]           = l;
    ch_tuser[k]           = u;
    ch_tdata[k*64 +: 64]  = d;
    ch_tkeep[k*8 +: 8]    = kp;
  endtask

  task automatic set_meta(input int k, input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    ch_src[k*16 +: 16] = s;
    ch_dst[k*16 +: 16] = d;
    ch_len[k*16 +: 16] = l;
  endtask

  // Every output must be at its reset value
  task automatic chk_zero(input string tag);
    chk({tag, " grant"}, 64'(grant), 64'h0);
    chk({tag, " busy"}, 64'(busy), 64'h0);
    chk({tag, " tvalid"}, 64'(o_tvalid), 64'h0);
    chk({tag, " tlast"}, 64'(o_tlast), 64'h0);
    chk({tag, " tuser"}, 64'(o_tuser), 64'h0);
    chk({tag, " tdata"}, o_tdata, 64'h0);
    chk({tag, " tkeep"}, 64'(o_tkeep), 64'h0);
    chk({tag, " ch_tready"}, 64'(ch_tready), 64'h0);
    chk({tag, " src"}, 64'(o_src), 64'h0);
    chk({tag, " dst"}, 64'(o_dst), 64'h0);
    chk({tag, " len"}, 64'(o_len), 64'h0);
  endtask

  function automatic logic [63:0] dpat(input int k, input int b);
    return {8'(8'hA0 + k), 48'h0, 8'(b)};
  endfunction

  function automatic logic [7:0] kpat(input int k, input int b);
    return 8'(16 * k + b + 1);
  endfunction

  typedef struct {
    logic [3:0] vld;
    logic [3:0] lst;
    logic       rdy;
    logic [3:0] gnt;
    logic       busy;
    logic       ovld;
    logic       olast;
    logic [3:0] crdy;
    int         och;   // channel expected on the output, -1 for none
    int         ob;    // beat index expected on the output
  } vec_t;

  function automatic vec_t mk(input logic [3:0] vld, input logic [3:0] lst, input logic rdy,
                              input logic [3:0] gnt, input logic bsy, input logic ovld,
                              input logic olast, input logic [3:0] crdy, input int och, input int ob);
    vec_t v;
    v.vld = vld; v.lst = lst; v.rdy = rdy; v.gnt = gnt; v.busy = bsy;
    v.ovld = ovld; v.olast = olast; v.crdy = crdy; v.och = och; v.ob = ob;
    return v;
  endfunction

  vec_t vecs [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int beat [NCH];

    // All four request 2-beat packets: order ch0,ch1,ch2,ch3,ch0 with one idle cycle between
    vecs[0]  = mk(4'b1111, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000, -1, 0);
    vecs[1]  = mk(4'b1111, 4'b0000, 1, 4'b0001, 1, 1, 0, 4'b0001,  0, 0);
    vecs[2]  = mk(4'b1111, 4'b0001, 1, 4'b0001, 1, 1, 1, 4'b0001,  0, 1);
    vecs[3]  = mk(4'b1111, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000, -1, 0);
    vecs[4]  = mk(4'b1111, 4'b0000, 1, 4'b0010, 1, 1, 0, 4'b0010,  1, 0);
    vecs[5]  = mk(4'b1111, 4'b0010, 1, 4'b0010, 1, 1, 1, 4'b0010,  1, 1);
    vecs[6]  = mk(4'b1111, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000, -1, 0);
    vecs[7]  = mk(4'b1111, 4'b0000, 1, 4'b0100, 1, 1, 0, 4'b0100,  2, 0);
    vecs[8]  = mk(4'b1111, 4'b0100, 1, 4'b0100, 1, 1, 1, 4'b0100,  2, 1);
    vecs[9]  = mk(4'b1111, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000, -1, 0);
    vecs[10] = mk(4'b1111, 4'b0000, 1, 4'b1000, 1, 1, 0, 4'b1000,  3, 0);
    vecs[11] = mk(4'b1111, 4'b1000, 1, 4'b1000, 1, 1, 1, 4'b1000,  3, 1);
    vecs[12] = mk(4'b1111, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000, -1, 0);
    vecs[13] = mk(4'b1111, 4'b0000, 1, 4'b0001, 1, 1, 0, 4'b0001,  0, 2);
    vecs[14] = mk(4'b1111, 4'b0001, 1, 4'b0001, 1, 1, 1, 4'b0001,  0, 3);
    vecs[15] = mk(4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000, -1, 0);
    // ch2 4-beat packet, downstream ready 1,0,0,1; ch0 requesting meanwhile is ignored
    vecs[16] = mk(4'b0100, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000, -1, 0);
    vecs[17] = mk(4'b0101, 4'b0001, 1, 4'b0100, 1, 1, 0, 4'b0100,  2, 2);
    vecs[18] = mk(4'b0101, 4'b0001, 0, 4'b0100, 1, 1, 0, 4'b0000,  2, 3);
    vecs[19] = mk(4'b0101, 4'b0001, 0, 4'b0100, 1, 1, 0, 4'b0000,  2, 3);
    vecs[20] = mk(4'b0101, 4'b0001, 1, 4'b0100, 1, 1, 0, 4'b0100,  2, 3);
    vecs[21] = mk(4'b0101, 4'b0001, 1, 4'b0100, 1, 1, 0, 4'b0100,  2, 4);
    vecs[22] = mk(4'b0101, 4'b0101, 1, 4'b0100, 1, 1, 1, 4'b0100,  2, 5);
    // rr_ptr=3: ch3 single-beat packet wins over ch0, then ch0
    vecs[23] = mk(4'b1001, 4'b1001, 1, 4'b0000, 0, 0, 0, 4'b0000, -1, 0);
    vecs[24] = mk(4'b1001, 4'b1001, 1, 4'b1000, 1, 1, 1, 4'b1000,  3, 2);
    vecs[25] = mk(4'b0001, 4'b0001, 1, 4'b0000, 0, 0, 0, 4'b0000, -1, 0);
    vecs[26] = mk(4'b0001, 4'b0001, 1, 4'b0001, 1, 1, 1, 4'b0001,  0, 4);
    vecs[27] = mk(4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000, -1, 0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single channel: ch1 3-beat packet
    @(negedge clk);
    set_meta(1, 16'h8080, 16'h8081, 16'd20);
    drive(1, 1, 0, 0, 64'h0123_4567_89AB_CDEF, 8'hFF);
    #1 chk("t1 grant before latency", 64'(grant), 64'h0);
    @(negedge clk);
    set_meta(1, 16'hDEAD, 16'hBEEF, 16'd999);
    #1;
    chk("t1 grant", 64'(grant), 64'h2);
    chk("t1 busy", 64'(busy), 64'h1);
    chk("t1 src", 64'(o_src), 64'h8080);
    chk("t1 dst", 64'(o_dst), 64'h8081);
    chk("t1 len", 64'(o_len), 64'd20);
    chk("t1 b0 tdata", o_tdata, 64'h0123_4567_89AB_CDEF);
    chk("t1 b0 tkeep", 64'(o_tkeep), 64'hFF);
    chk("t1 b0 tvalid", 64'(o_tvalid), 64'h1);
    chk("t1 b0 tlast", 64'(o_tlast), 64'h0);
    chk("t1 ch_tready", 64'(ch_tready), 64'h2);
    @(negedge clk);
    drive(1, 1, 0, 0, 64'h1111_2222_3333_4444, 8'hFF);
    #1;
    chk("t1 b1 tdata", o_tdata, 64'h1111_2222_3333_4444);
    chk("t1 b1 tlast", 64'(o_tlast), 64'h0);
    @(negedge clk);
    drive(1, 1, 1, 0, 64'h0000_0000_5566_7788, 8'h0F);
    #1;
    chk("t1 b2 tdata", o_tdata, 64'h0000_0000_5566_7788);
    chk("t1 b2 tkeep", 64'(o_tkeep), 64'h0F);
    chk("t1 b2 tlast", 64'(o_tlast), 64'h1);
    chk("t1 b2 busy", 64'(busy), 64'h1);
    @(negedge clk);
    drive(1, 0, 0, 0, 64'h0, 8'h00);
    #1;
    chk("t1 busy after last", 64'(busy), 64'h0);
    chk("t1 grant after last", 64'(grant), 64'h0);
    chk("t1 src held", 64'(o_src), 64'h8080);
    chk("t1 tvalid idle", 64'(o_tvalid), 64'h0);

    // Reset during beat 2 of a 5-beat packet on ch2 (rr_ptr is 2 here)
    @(negedge clk);
    set_meta(2, 16'h1234, 16'h5678, 16'd40);
    drive(2, 1, 0, 1, 64'hE0E0_E0E0_E0E0_E0E0, 8'hFF);
    @(negedge clk);
    #1 chk("t5 grant", 64'(grant), 64'h4);
    @(negedge clk);
    drive(2, 1, 0, 1, 64'hE1E1_E1E1_E1E1_E1E1, 8'hFF);
    #1 chk("t5 beat2 tdata", o_tdata, 64'hE1E1_E1E1_E1E1_E1E1);
    #2 rst_n = 1'b0;
    #1 chk_zero("t5 async reset");
    @(negedge clk);
    drive(2, 0, 0, 0, 64'h0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: arbitration restarts at ch0 after reset, then RR order, backpressure, wrap
    for (int k = 0; k < NCH; k++) beat[k] = 0;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      for (int k = 0; k < NCH; k++)
        drive(k, vecs[i].vld[k], vecs[i].lst[k], (k == 3), dpat(k, beat[k]), kpat(k, beat[k]));
      ds_ready = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d grant", i), 64'(grant), 64'(vecs[i].gnt));
      chk($sformatf("v%0d busy", i), 64'(busy), 64'(vecs[i].busy));
      chk($sformatf("v%0d tvalid", i), 64'(o_tvalid), 64'(vecs[i].ovld));
      chk($sformatf("v%0d tlast", i), 64'(o_tlast), 64'(vecs[i].olast));
      chk($sformatf("v%0d ch_tready", i), 64'(ch_tready), 64'(vecs[i].crdy));
      if (vecs[i].och >= 0) begin
        chk($sformatf("v%0d tdata", i), o_tdata, dpat(vecs[i].och, vecs[i].ob));
        chk($sformatf("v%0d tkeep", i), 64'(o_tkeep), 64'(kpat(vecs[i].och, vecs[i].ob)));
        chk($sformatf("v%0d tuser", i), 64'(o_tuser), 64'(vecs[i].och == 3));
      end
      for (int k = 0; k < NCH; k++)
        if (vecs[i].vld[k] && vecs[i].crdy[k]) beat[k]++;
    end

`ifdef UDP_ARB_TIMEOUT_EN
    // Watchdog: ch0 stalls after beat 1; synthetic beat, drain, then ch1 (rr_ptr is 1 here)
    @(negedge clk);
    ds_ready = 1'b1;
    drive(0, 1, 0, 0, 64'hF0, 8'hFF);
    @(negedge clk);
    #1;
    chk("to grant", 64'(grant), 64'h1);
    chk("to beat1 tvalid", 64'(o_tvalid), 64'h1);
    @(negedge clk);
    drive(0, 0, 0, 0, 64'h0, 8'h00);
    drive(1, 1, 1, 0, 64'hC1C1, 8'hFF);
    for (int s = 0; s < 16; s++) begin
      #1 chk($sformatf("to stall%0d tvalid", s), 64'(o_tvalid), 64'h0);
      @(negedge clk);
    end
    ds_ready = 1'b0;
    #1;
    chk("to synth tvalid", 64'(o_tvalid), 64'h1);
    chk("to synth tlast", 64'(o_tlast), 64'h1);
    chk("to synth tuser", 64'(o_tuser), 64'h1);
    chk("to synth tkeep", 64'(o_tkeep), 64'h01);
    chk("to synth tdata", o_tdata, 64'h0);
    chk("to synth ch_tready", 64'(ch_tready), 64'h0);
    @(negedge clk);
    ds_ready = 1'b1;
    #1 chk("to synth held", 64'(o_tvalid), 64'h1);
    @(negedge clk);
    ds_ready = 1'b0;
    drive(0, 1, 0, 0, 64'hF1, 8'hFF);
    #1;
    chk("to flush ch_tready", 64'(ch_tready), 64'h1);
    chk("to flush tvalid", 64'(o_tvalid), 64'h0);
    chk("to flush busy", 64'(busy), 64'h1);
    @(negedge clk);
    drive(0, 1, 1, 0, 64'hF2, 8'hFF);
    #1;
    chk("to flush last ch_tready", 64'(ch_tready), 64'h1);
    chk("to flush last tvalid", 64'(o_tvalid), 64'h0);
    @(negedge clk);
    ds_ready = 1'b1;
    drive(0, 1, 0, 0, 64'hF3, 8'hFF);
    #1 chk("to idle busy", 64'(busy), 64'h0);
    @(negedge clk);
    #1;
    chk("to next grant", 64'(grant), 64'h2);
    chk("to next tdata", o_tdata, 64'hC1C1);
    @(negedge clk);
    drive(0, 0, 0, 0, 64'h0, 8'h00);
    drive(1, 0, 0, 0, 64'h0, 8'h00);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
